// File: rtl/us_sched_pkg.sv
// Shared types for the ultrasonic ranger scheduler: FSM states, channel indices and distance limit.
package us_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  localparam logic [9:0] MAX_CM   = 10'd999;
  localparam logic [1:0] CH_FRONT = 2'd0;
  localparam logic [1:0] CH_RIGHT = 2'd1;
  localparam logic [1:0] CH_LEFT  = 2'd2;

  // Round-robin order front -> right -> left -> front.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_LEFT) ? CH_FRONT : ch + 2'd1;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// 1 us tick divider; tick is a one-cycle pulse every CLK_HZ/1e6 clocks, restarted by clr.
module us_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Combinational tick so a state lasting N ticks spans exactly N*DIV clocks after a clear.
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset_p || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Time-multiplexed scheduler for three echo rangers with one shared us/cm counter pair.
// Optional macro US_AVG_EN: average each good result with the previous one per channel.
module ultrasonic_scheduler
  import us_sched_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 10000,
  parameter int US_PER_CM  = 58
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        enable,
  input  logic [2:0]  echo,
  output logic [2:0]  trig,
  output logic [15:0] distance_front,
  output logic [15:0] distance_right,
  output logic [15:0] distance_left,
  output logic [2:0]  dist_valid,
  output logic [2:0]  timeout,
  output logic        busy
);

  localparam int TMAX = (TIMEOUT_US > GAP_US)
                        ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                        : ((GAP_US > TRIG_US) ? GAP_US : TRIG_US);
  localparam int TW = $clog2(TMAX + 1);
  localparam int UW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  state_t        state, state_next;
  logic [1:0]    sel;
  logic [TW-1:0] tcnt, limit;
  logic [UW-1:0] us_cnt;
  logic [9:0]    cm_cnt, cm_final;
  logic [2:0]    echo_m, echo_s, echo_d;
  logic          echo_rise, echo_fall;
  logic          tick, entry, tick_clr, timer_done, cm_inc;
  logic          wr_en, wr_timeout;
  logic [15:0]   filt, wr_value;
  logic [15:0]   dist_q [3];

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (tick_clr),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset_p) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign echo_rise = echo_s[sel] & ~echo_d[sel];
  assign echo_fall = ~echo_s[sel] & echo_d[sel];

  always_comb begin
    limit = '0;
    case (state)
      TRIG:              limit = TW'(TRIG_US - 1);
      WAIT_RISE, MEASURE: limit = TW'(TIMEOUT_US - 1);
      GAP:               limit = TW'(GAP_US - 1);
      default:           limit = '0;
    endcase
    timer_done = tick && (tcnt == limit);
  end

  // A falling edge wins over a coinciding timeout so a complete echo is never discarded.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_timeout = 1'b0;
    case (state)
      IDLE:      if (enable) state_next = TRIG;
      TRIG:      if (timer_done) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
        end else if (timer_done) begin
          state_next = GAP;
          wr_en      = 1'b1;
          wr_timeout = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_next = GAP;
          wr_en      = 1'b1;
        end else if (timer_done) begin
          state_next = GAP;
          wr_en      = 1'b1;
          wr_timeout = 1'b1;
        end
      end
      GAP:       if (timer_done) state_next = enable ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign entry    = (state_next != state);
  assign tick_clr = entry || (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p || entry) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // cm_final folds in a centimetre completed on the very cycle the echo falls.
  assign cm_inc   = tick && (us_cnt == UW'(US_PER_CM - 1));
  assign cm_final = (cm_inc && (cm_cnt != MAX_CM)) ? cm_cnt + 10'd1 : cm_cnt;

  always_ff @(posedge clk) begin
    if (reset_p || entry) begin
      us_cnt <= '0;
      cm_cnt <= '0;
    end else if ((state == MEASURE) && tick) begin
      us_cnt <= cm_inc ? '0 : us_cnt + 1'b1;
      cm_cnt <= cm_final;
    end
  end

`ifdef US_AVG_EN
  logic [2:0]  have_q;
  logic [16:0] avg_sum;

  assign avg_sum = {1'b0, dist_q[sel]} + {7'd0, cm_final};
  assign filt    = have_q[sel] ? 16'(avg_sum >> 1) : {6'd0, cm_final};

  always_ff @(posedge clk) begin
    if (reset_p) begin
      have_q <= '0;
    end else if (wr_en) begin
      have_q[sel] <= ~wr_timeout;
    end
  end
`else
  assign filt = {6'd0, cm_final};
`endif

  assign wr_value = wr_timeout ? {6'd0, MAX_CM} : filt;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      dist_q     <= '{default: '0};
      dist_valid <= '0;
      timeout    <= '0;
      sel        <= CH_FRONT;
    end else begin
      dist_valid <= '0;
      if (wr_en) begin
        dist_q[sel]     <= wr_value;
        dist_valid[sel] <= 1'b1;
        timeout[sel]    <= wr_timeout;
      end
      if ((state == GAP) && timer_done) begin
        sel <= next_ch(sel);
      end
    end
  end

  assign trig           = (state == TRIG) ? 3'(3'b001 << sel) : 3'b000;
  assign busy           = (state != IDLE);
  assign distance_front = dist_q[CH_FRONT];
  assign distance_right = dist_q[CH_RIGHT];
  assign distance_left  = dist_q[CH_LEFT];

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Randomized self-checking bench for ultrasonic_scheduler with scaled-down timing parameters.
module tb_ultrasonic_scheduler;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int GAP_US     = 20;
  localparam int US_PER_CM  = 4;
  localparam int MAX_CM     = 999;

  localparam int K_NORM  = 0;
  localparam int K_NONE  = 1;
  localparam int K_LONG  = 2;
  localparam int K_DROP  = 3;
  localparam int K_RESET = 4;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        enable;
  logic [2:0]  echo;
  logic [2:0]  trig;
  logic [15:0] distance_front, distance_right, distance_left;
  logic [2:0]  dist_valid, timeout;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int exp_dist [3];
  bit exp_to [3];
  bit have [3];
  int exp_ch;

  always #5 clk = ~clk;

  ultrasonic_scheduler #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .GAP_US     (GAP_US),
    .US_PER_CM  (US_PER_CM)
  ) dut (
    .clk            (clk),
    .reset_p        (reset_p),
    .enable         (enable),
    .echo           (echo),
    .trig           (trig),
    .distance_front (distance_front),
    .distance_right (distance_right),
    .distance_left  (distance_left),
    .dist_valid     (dist_valid),
    .timeout        (timeout),
    .busy           (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Only one ranger may be firing at any time.
  always @(negedge clk) begin
    if (reset_p === 1'b0) checkOutput("trig_onehot", 32'($countones(trig) <= 1), 1);
  end

  // Reference: distance is the echo width in whole centimetres, or 999 on any timeout.
  function automatic void model_result(input int ch, input int w_us, input bit echoed);
    int cm;
    if (!echoed || (w_us >= TIMEOUT_US)) begin
      exp_dist[ch] = MAX_CM;
      exp_to[ch]   = 1'b1;
      have[ch]     = 1'b0;
    end else begin
      cm = w_us / US_PER_CM;
      if (cm > MAX_CM) cm = MAX_CM;
`ifdef US_AVG_EN
      if (have[ch]) cm = (exp_dist[ch] + cm) / 2;
`endif
      exp_dist[ch] = cm;
      exp_to[ch]   = 1'b0;
      have[ch]     = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_dist[i] = 0;
      exp_to[i]   = 1'b0;
      have[i]     = 1'b0;
    end
    exp_ch = 0;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_trig"}, 32'(trig), 0);
    checkOutput({tag, "_front"}, 32'(distance_front), 0);
    checkOutput({tag, "_right"}, 32'(distance_right), 0);
    checkOutput({tag, "_left"}, 32'(distance_left), 0);
    checkOutput({tag, "_valid"}, 32'(dist_valid), 0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One channel slot: observe the trigger, answer with an echo, check the written result.
  task automatic applyStimulus(input int kind, input int w_us, input int d_us);
    int n;
    int ch;
    n = 0;
    while ((trig == 3'b000) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_seen", 32'(trig != 3'b000), 1);
    if (trig == 3'b000) return;
    ch = trig[0] ? 0 : (trig[1] ? 1 : 2);
    checkOutput("trig_order", 32'(ch), 32'(exp_ch));
    n = 0;
    while (trig[ch] && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_width_clks", 32'(n), 32'(TRIG_US * DIV));
    repeat (d_us * DIV) @(negedge clk);

    if (kind != K_NONE) begin
      echo[ch] = 1'b1;
      fork
        begin
          automatic int c = ch;
          automatic int w = w_us;
          repeat (w * DIV) @(negedge clk);
          echo[c] = 1'b0;
        end
      join_none
    end

    if (kind == K_DROP) begin
      repeat ((w_us / 2) * DIV) @(negedge clk);
      enable = 1'b0;
    end

    if (kind == K_RESET) begin
      repeat ((w_us / 2) * DIV) @(negedge clk);
      reset_p = 1'b1;
      enable  = 1'b0;
      @(negedge clk);
      reset_p = 1'b0;
      checkAllZero("reset_mid_measure");
      model_reset();
      repeat ((w_us + 20) * DIV) @(negedge clk);
      checkOutput("reset_no_result", 32'(dist_valid), 0);
      enable = 1'b1;
      return;
    end

    n = 0;
    while ((dist_valid == 3'b000) && (n < (2 * TIMEOUT_US + 100) * DIV)) begin
      @(negedge clk);
      n++;
    end
    model_result(ch, w_us, kind != K_NONE);
    checkOutput("dist_valid_onehot", 32'(dist_valid), 32'(1) << ch);
    checkOutput("distance_front", 32'(distance_front), 32'(exp_dist[0]));
    checkOutput("distance_right", 32'(distance_right), 32'(exp_dist[1]));
    checkOutput("distance_left", 32'(distance_left), 32'(exp_dist[2]));
    checkOutput("timeout_flags", 32'(timeout), 32'({exp_to[2], exp_to[1], exp_to[0]}));
    @(negedge clk);
    checkOutput("dist_valid_single", 32'(dist_valid), 0);
    exp_ch = (ch + 1) % 3;

    if (kind == K_DROP) begin
      n = 0;
      while (busy && (n < (GAP_US + 5) * DIV)) begin
        @(negedge clk);
        n++;
      end
      checkOutput("idle_after_drop", 32'(busy), 0);
      repeat (30) @(negedge clk);
      checkOutput("idle_no_trig", 32'(trig), 0);
      checkOutput("idle_busy", 32'(busy), 0);
      enable = 1'b1;
    end
  endtask

  initial begin
    int kind;
    reset_p = 1'b1;
    enable  = 1'b0;
    echo    = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    checkAllZero("reset_state");
    enable = 1'b1;

    applyStimulus(K_NORM, 40, 5);
    applyStimulus(K_NONE, 0, 0);
    applyStimulus(K_LONG, 260, 5);
    applyStimulus(K_NORM, 80, 7);
    applyStimulus(K_NORM, 80, 3);
    applyStimulus(K_DROP, 20, 4);
    applyStimulus(K_RESET, 64, 6);
    applyStimulus(K_NORM, 80, 2);
    applyStimulus(K_NORM, 41, 9);
    applyStimulus(K_NORM, 123, 0);
    applyStimulus(K_NORM, 160, 4);

    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0:       applyStimulus(K_NONE, 0, 0);
        1:       applyStimulus(K_LONG, $urandom_range(230, 300), $urandom_range(0, 60));
        2:       applyStimulus(K_DROP, $urandom_range(4, 180), $urandom_range(0, 60));
        default: applyStimulus(K_NORM, $urandom_range(4, 180), $urandom_range(0, 60));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
